// File: rtl/ibex_dbus_arbiter.sv
// Two-host to one-device arbiter for the Ibex data bus (req/gnt/rvalid), zero added latency.
// Optional build macro IBEX_DBUS_ARB_FIXED_PRIO_EN selects fixed priority (host 0) instead of round-robin.
module ibex_dbus_arbiter #(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    // host 0 (core)
    input  logic                   h0_req_i,
    output logic                   h0_gnt_o,
    input  logic                   h0_we_i,
    input  logic [DataWidth/8-1:0] h0_be_i,
    input  logic [AddrWidth-1:0]   h0_addr_i,
    input  logic [DataWidth-1:0]   h0_wdata_i,
    output logic                   h0_rvalid_o,
    output logic [DataWidth-1:0]   h0_rdata_o,
    output logic                   h0_err_o,
    // host 1 (secondary)
    input  logic                   h1_req_i,
    output logic                   h1_gnt_o,
    input  logic                   h1_we_i,
    input  logic [DataWidth/8-1:0] h1_be_i,
    input  logic [AddrWidth-1:0]   h1_addr_i,
    input  logic [DataWidth-1:0]   h1_wdata_i,
    output logic                   h1_rvalid_o,
    output logic [DataWidth-1:0]   h1_rdata_o,
    output logic                   h1_err_o,
    // device
    output logic                   data_req_o,
    input  logic                   data_gnt_i,
    input  logic                   data_rvalid_i,
    output logic                   data_we_o,
    output logic [DataWidth/8-1:0] data_be_o,
    output logic [AddrWidth-1:0]   data_addr_o,
    output logic [DataWidth-1:0]   data_wdata_o,
    input  logic [DataWidth-1:0]   data_rdata_i,
    input  logic                   data_err_i
);

    localparam int unsigned PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CW = $clog2(MaxOutstanding + 1);

    typedef enum logic {ST_IDLE, ST_HOLD} state_e;

    state_e          r_state;
    logic            r_lock;
    logic            r_ids [MaxOutstanding];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic            w_winner;
    logic            w_sel;
    logic            w_sel_req;
    logic            w_full;
    logic            w_req;
    logic            w_grant;
    logic            w_pop;
    logic            w_head;

`ifdef IBEX_DBUS_ARB_FIXED_PRIO_EN
    always_comb begin
        w_winner = !h0_req_i;
    end
`else
    logic            r_last;

    // Tie goes to whichever host did not win the previous grant.
    always_comb begin
        w_winner = !h0_req_i;
        if (h0_req_i && h1_req_i) w_winner = !r_last;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)        r_last <= 1'b1;
        else if (w_grant) r_last <= w_sel;
    end
`endif

    assign w_sel     = (r_state == ST_HOLD) ? r_lock : w_winner;
    assign w_sel_req = w_sel ? h1_req_i : h0_req_i;
    // Registered count only: a response popping this cycle does not open a slot yet.
    assign w_full    = (r_count == CW'(MaxOutstanding));
    assign w_req     = !rst_i && w_sel_req && ((r_state == ST_HOLD) || !w_full);
    assign w_grant   = w_req && data_gnt_i;
    assign w_pop     = !rst_i && data_rvalid_i && (r_count != '0);
    assign w_head    = r_ids[r_rptr];

    always_comb begin
        data_req_o   = w_req;
        data_we_o    = 1'b0;
        data_be_o    = '0;
        data_addr_o  = '0;
        data_wdata_o = '0;
        if (!rst_i) begin
            data_we_o    = w_sel ? h1_we_i    : h0_we_i;
            data_be_o    = w_sel ? h1_be_i    : h0_be_i;
            data_addr_o  = w_sel ? h1_addr_i  : h0_addr_i;
            data_wdata_o = w_sel ? h1_wdata_i : h0_wdata_i;
        end
    end

    assign h0_gnt_o    = w_grant && !w_sel;
    assign h1_gnt_o    = w_grant &&  w_sel;
    assign h0_rvalid_o = w_pop && !w_head;
    assign h1_rvalid_o = w_pop &&  w_head;
    assign h0_err_o    = h0_rvalid_o && data_err_i;
    assign h1_err_o    = h1_rvalid_o && data_err_i;
    assign h0_rdata_o  = rst_i ? '0 : data_rdata_i;
    assign h1_rdata_o  = rst_i ? '0 : data_rdata_i;

    // HOLD keeps the address phase stable on the locked host until the device grants.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_lock  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_req && !data_gnt_i) begin
                    r_state <= ST_HOLD;
                    r_lock  <= w_winner;
                end
                ST_HOLD: if (data_gnt_i) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(MaxOutstanding); i++) r_ids[i] <= 1'b0;
        end else begin
            if (w_grant) begin
                r_ids[r_wptr] <= w_sel;
                r_wptr <= (r_wptr == PW'(MaxOutstanding - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PW'(MaxOutstanding - 1)) ? '0 : r_rptr + 1'b1;
            end
            if (w_grant && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_grant && w_pop) r_count <= r_count - 1'b1;
        end
    end

endmodule
